// File: rtl/addr_lane_gen_pkg.sv
//------------------------------------------------------------------------------
// addr_lane_gen_pkg : constants and types shared by the lane address generators
//                     and the downstream lane address-alignment stage.
// Revision          : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package addr_lane_gen_pkg;

    localparam int unsigned   AW        = 12;
    localparam int unsigned   NUM_LANES = 4;
    localparam logic [AW-1:0] LANE_OFS  = 12'd9;
    localparam logic [AW-1:0] IDLE_ADDR = 12'd4091;
    localparam logic [AW-1:0] MAX_ADDR  = 12'd4090;
    localparam logic [5:0]    OP_ABS    = 6'd5;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage : addr_lane_gen_pkg

`default_nettype wire

// File: rtl/addr_range_chk.sv
//------------------------------------------------------------------------------
// addr_range_chk : flags whether the last lane address of a sweep stays at or
//                  below MAX_ADDR.
// Revision       : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module addr_range_chk
    import addr_lane_gen_pkg::*;
(
    input  logic [AW-1:0] base_addr,
    input  logic [AW-1:0] len,
    input  logic          abs_mode,
    output logic          range_ok
);

    localparam logic [AW+1:0] LANE_SPAN = (AW+2)'(3 * LANE_OFS);

    logic [AW+1:0] w_end_addr;

    // Two extra bits keep base + len + span from wrapping before the compare.
    always_comb begin
        w_end_addr = {2'b00, base_addr} + {2'b00, len} - (AW+2)'(1);
        if (!abs_mode) begin
            w_end_addr = w_end_addr + LANE_SPAN;
        end
        range_ok = (w_end_addr <= {2'b00, MAX_ADDR});
    end

endmodule : addr_range_chk

`default_nettype wire

// File: rtl/addr_lane_gen.sv
//------------------------------------------------------------------------------
// addr_lane_gen : sweeps an index over a block and produces four lane
//                 addresses, offset per lane unless in absolute mode.
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module addr_lane_gen
    import addr_lane_gen_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [5:0]    instr_fb,
    input  logic [AW-1:0] base_addr,
    input  logic [AW-1:0] len,
    input  logic          adv,
    output logic [AW-1:0] addr1,
    output logic [AW-1:0] addr2,
    output logic [AW-1:0] addr3,
    output logic [AW-1:0] addr4,
    output logic          addr_vld,
    output logic          busy,
    output logic          done,
    output logic          err
);

    state_e        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [AW-1:0] base_q, base_d;
    logic [AW-1:0] len_q, len_d;
    logic          abs_q, abs_d;
    logic [AW-1:0] addr_q [NUM_LANES];
    logic [AW-1:0] addr_d [NUM_LANES];
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          w_start_abs;
    logic          w_range_ok;
    logic          w_last_step;

    assign w_start_abs = (instr_fb == OP_ABS);
    assign w_last_step = (idx_q == len_q - AW'(1));

    addr_range_chk u_range_chk (
        .base_addr (base_addr),
        .len       (len),
        .abs_mode  (w_start_abs),
        .range_ok  (w_range_ok)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            base_q  <= '0;
            len_q   <= '0;
            abs_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int k = 0; k < NUM_LANES; k++) begin
                addr_q[k] <= IDLE_ADDR;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
            len_q   <= len_d;
            abs_q   <= abs_d;
            done_q  <= done_d;
            err_q   <= err_d;
            for (int k = 0; k < NUM_LANES; k++) begin
                addr_q[k] <= addr_d[k];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        base_d  = base_q;
        len_d   = len_q;
        abs_d   = abs_q;
        if (state_q == IDLE) begin
            if (start && (len != '0) && w_range_ok) begin
                state_d = RUN;
                idx_d   = '0;
                base_d  = base_addr;
                len_d   = len;
                abs_d   = w_start_abs;
            end
        end else if (adv) begin
            if (w_last_step) begin
                state_d = IDLE;
                idx_d   = '0;
            end else begin
                idx_d = idx_q + AW'(1);
            end
        end
    end

    // The range check guarantees the AW-bit lane sums never wrap.
    always_comb begin
        done_d = 1'b0;
        err_d  = 1'b0;
        if (state_q == IDLE && start) begin
            done_d = (len == '0);
            err_d  = (len != '0) && !w_range_ok;
        end
        if (state_q == RUN && adv && w_last_step) begin
            done_d = 1'b1;
        end
        for (int k = 0; k < NUM_LANES; k++) begin
            if (state_d == RUN) begin
                addr_d[k] = base_d + idx_d + (abs_d ? '0 : AW'(k) * LANE_OFS);
            end else begin
                addr_d[k] = IDLE_ADDR;
            end
        end
    end

    assign addr1    = addr_q[0];
    assign addr2    = addr_q[1];
    assign addr3    = addr_q[2];
    assign addr4    = addr_q[3];
    assign addr_vld = (state_q == RUN);
    assign busy     = (state_q == RUN);
    assign done     = done_q;
    assign err      = err_q;

endmodule : addr_lane_gen

`default_nettype wire
